// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: raster pixel stream in, one registered window per valid beat.
// Optional build macro CONV_WIN_STRIDE2_EN decimates the emitted windows to stride 2.
module conv_window_gen #(
  parameter int F = 28,
  parameter int B = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_sof,
  input  logic [B-1:0]   i_pixel,
  input  logic           i_pixel_valid,
  output logic [9*B-1:0] o_pixel_data,
  output logic           o_pixel_data_valid,
  output logic           o_frame_done
);

  localparam int CW = (F > 1) ? $clog2(F) : 1;
  localparam logic [CW-1:0] LAST = CW'(F - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t          state_q, state_d, state_eff;
  logic [CW-1:0]   col_q, col_d, col_eff;
  logic [CW-1:0]   row_q, row_d, row_eff;
  logic            col_end, row_end;
  logic            emit_d, frame_end_d;

  logic [B-1:0]    lb0_q [F];
  logic [B-1:0]    lb1_q [F];
  logic [B-1:0]    tap1, tap2;
  logic [B-1:0]    win_q [3][3];
  logic [B-1:0]    win_d [3][3];
  logic [9*B-1:0]  win_flat;

  logic [9*B-1:0]  data_q;
  logic            vld_q;
  logic            done_q;

  // A start-of-frame beat is processed as pixel (0,0) of a fresh frame.
  always_comb begin
    col_eff   = i_sof ? '0 : col_q;
    row_eff   = i_sof ? '0 : row_q;
    state_eff = i_sof ? S_FILL : state_q;
    col_end   = (col_eff == LAST);
    row_end   = (row_eff == LAST);
    tap1      = lb0_q[col_eff];
    tap2      = lb1_q[col_eff];
  end

  always_comb begin
    emit_d = i_pixel_valid && (state_eff == S_RUN) && (col_eff >= TWO);
`ifdef CONV_WIN_STRIDE2_EN
    // Rows and columns start emitting at index 2, so even index == even offset.
    emit_d = emit_d && !col_eff[0] && !row_eff[0];
`endif
    frame_end_d = i_pixel_valid && (state_eff == S_RUN) && col_end && row_end;
  end

  always_comb begin
    col_d   = col_eff;
    row_d   = row_eff;
    state_d = state_eff;
    if (i_pixel_valid) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_eff + ONE;
      end else begin
        col_d = col_eff + ONE;
      end
      case (state_eff)
        S_FILL: if (col_end && (row_eff == ONE)) state_d = S_RUN;
        S_RUN:  if (col_end && row_end)          state_d = S_FILL;
        default:                                 state_d = S_FILL;
      endcase
    end
  end

  // Window shifts left by one column; the new right column is the two taps plus the new pixel.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = tap2;
    win_d[1][2] = tap1;
    win_d[2][2] = i_pixel;
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_flat[(3*r+c)*B +: B] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= S_FILL;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      vld_q   <= emit_d;
      done_q  <= frame_end_d;
      if (emit_d) data_q <= win_flat;
    end
  end

  // Line buffers and shift array are datapath only; stale contents are gated by the FSM.
  always_ff @(posedge i_clk) begin
    if (i_pixel_valid) begin
      lb1_q[col_eff] <= tap1;
      lb0_q[col_eff] <= i_pixel;
      win_q          <= win_d;
    end
  end

  assign o_pixel_data       = data_q;
  assign o_pixel_data_valid = vld_q;
  assign o_frame_done       = done_q;

endmodule
